// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide coprocessor:
// register window layout, CTRL/STATUS bit positions and engine enums.
package mdu_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  typedef enum logic {MUL = 1'b0, DIV = 1'b1} op_t;

  localparam int unsigned CTRL_OP_BIT     = 0;
  localparam int unsigned CTRL_SIGNED_BIT = 1;
  localparam int unsigned CTRL_START_BIT  = 7;
  localparam int unsigned STAT_BUSY_BIT   = 0;
  localparam int unsigned STAT_DZ_BIT     = 1;

  localparam int unsigned SLOT_ARG0   = 0;
  localparam int unsigned SLOT_ARG1   = 1;
  localparam int unsigned SLOT_RES_LO = 2;
  localparam int unsigned SLOT_RES_HI = 3;
  localparam int unsigned SLOT_CTRL   = 4;

  // Each operand/result register occupies b bytes; CTRL and STATUS follow.
  function automatic int unsigned reg_off(input int unsigned slot, input int unsigned b);
    return slot * b;
  endfunction

  function automatic int unsigned status_off(input int unsigned b);
    return SLOT_CTRL * b + 1;
  endfunction

endpackage

// File: rtl/mdu_core.sv
// Iterative engine: shift-add multiply / restoring divide on operand
// magnitudes, one bit per cycle, sign correction in the FIX cycle.
module mdu_core
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  op_t              op,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             commit,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  op_t              op_q;
  logic             sgn_q;
  logic [WIDTH-1:0] a_q, b_q, mb, hi, lo;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic               neg_q, neg_r;
  logic [2*WIDTH-1:0] prod;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
    return (s && x[WIDTH-1]) ? -x : x;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    commit = (state == FIX);
  end

  // hi:lo is the product accumulator for MUL and remainder:quotient for DIV.
  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, mb} : '0);
    div_sh   = {hi, lo[WIDTH-1]};
    div_diff = div_sh - {1'b0, mb};
    div_ge   = (div_sh >= {1'b0, mb});
    div_rem  = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= MUL;
      sgn_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      mb    <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= (state == FIX);
      case (state)
        IDLE: if (start) begin
          op_q  <= op;
          sgn_q <= sgn;
          a_q   <= a;
          b_q   <= b;
          hi    <= '0;
          lo    <= mag(a, sgn);
          mb    <= mag(b, sgn);
          cnt   <= CW'(WIDTH - 1);
        end
        RUN: begin
          if (op_q == MUL) {hi, lo} <= {mul_sum, lo[WIDTH-1:1]};
          else             {hi, lo} <= {div_rem, lo[WIDTH-2:0], div_ge};
          cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // MIN / -1 needs no special case: negating the magnitude 2^(W-1) wraps back to MIN.
  always_comb begin
    neg_q  = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    neg_r  = sgn_q & a_q[WIDTH-1];
    prod   = neg_q ? -{hi, lo} : {hi, lo};
    dz     = 1'b0;
    res_lo = prod[WIDTH-1:0];
    res_hi = prod[2*WIDTH-1:WIDTH];
    if (op_q == DIV) begin
      if (b_q == '0) begin
        dz     = 1'b1;
        res_lo = '1;
        res_hi = a_q;
      end else begin
        res_lo = neg_q ? -lo : lo;
        res_hi = neg_r ? -hi : hi;
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Byte-bus register window around the iterative multiply/divide engine:
// operand/result registers, CTRL/STATUS decode and combinational read mux.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned AUTO_START = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [REG_AW-1:0] bus_addr,
  input  logic              bus_we,
  input  logic [7:0]        bus_wdata,
  output logic [7:0]        bus_rdata,
  output logic              busy,
  output logic              done
);

  localparam int unsigned B = WIDTH / 8;
  localparam logic [REG_AW-1:0] A_ARG0   = REG_AW'(reg_off(SLOT_ARG0, B));
  localparam logic [REG_AW-1:0] A_ARG1   = REG_AW'(reg_off(SLOT_ARG1, B));
  localparam logic [REG_AW-1:0] A_RES_LO = REG_AW'(reg_off(SLOT_RES_LO, B));
  localparam logic [REG_AW-1:0] A_RES_HI = REG_AW'(reg_off(SLOT_RES_HI, B));
  localparam logic [REG_AW-1:0] A_CTRL   = REG_AW'(reg_off(SLOT_CTRL, B));
  localparam logic [REG_AW-1:0] A_STATUS = REG_AW'(status_off(B));
  localparam logic [REG_AW-1:0] A_ARG1_TOP = A_ARG1 + REG_AW'(B - 1);

  logic [WIDTH-1:0] arg0, arg1, arg0_nxt, arg1_nxt, res_lo, res_hi;
  logic [WIDTH-1:0] core_lo, core_hi;
  op_t              mode_op, start_op;
  logic             mode_sgn, start_sgn, dz;
  logic             ctrl_wr, ctrl_start, auto_start, start, commit, core_dz;

  always_comb begin
    arg0_nxt = arg0;
    arg1_nxt = arg1;
    for (int unsigned i = 0; i < B; i++) begin
      if (bus_we && bus_addr == A_ARG0 + REG_AW'(i)) arg0_nxt[8*i +: 8] = bus_wdata;
      if (bus_we && bus_addr == A_ARG1 + REG_AW'(i)) arg1_nxt[8*i +: 8] = bus_wdata;
    end
  end

  // CTRL writes are dropped entirely while busy (including FIX), so the mode is untouched.
  always_comb begin
    ctrl_wr    = bus_we && (bus_addr == A_CTRL) && !busy;
    ctrl_start = ctrl_wr && bus_wdata[CTRL_START_BIT];
    auto_start = (AUTO_START != 0) && bus_we && (bus_addr == A_ARG1_TOP) && !busy;
    start      = ctrl_start || auto_start;
    start_op   = ctrl_start ? op_t'(bus_wdata[CTRL_OP_BIT]) : mode_op;
    start_sgn  = ctrl_start ? bus_wdata[CTRL_SIGNED_BIT] : mode_sgn;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      arg0     <= '0;
      arg1     <= '0;
      res_lo   <= '0;
      res_hi   <= '0;
      mode_op  <= MUL;
      mode_sgn <= 1'b0;
      dz       <= 1'b0;
    end else begin
      arg0 <= arg0_nxt;
      arg1 <= arg1_nxt;
      if (ctrl_wr) begin
        mode_op  <= op_t'(bus_wdata[CTRL_OP_BIT]);
        mode_sgn <= bus_wdata[CTRL_SIGNED_BIT];
      end
      if (commit) begin
        res_lo <= core_lo;
        res_hi <= core_hi;
        dz     <= core_dz;
      end
    end
  end

  mdu_core #(.WIDTH(WIDTH)) u_core (
    .clk    (CLK),
    .rst    (RST),
    .start  (start),
    .op     (start_op),
    .sgn    (start_sgn),
    .a      (arg0_nxt),
    .b      (arg1_nxt),
    .busy   (busy),
    .commit (commit),
    .done   (done),
    .dz     (core_dz),
    .res_lo (core_lo),
    .res_hi (core_hi)
  );

  always_comb begin
    bus_rdata = '0;
    for (int unsigned i = 0; i < B; i++) begin
      if (bus_addr == A_ARG0 + REG_AW'(i))   bus_rdata = arg0[8*i +: 8];
      if (bus_addr == A_ARG1 + REG_AW'(i))   bus_rdata = arg1[8*i +: 8];
      if (bus_addr == A_RES_LO + REG_AW'(i)) bus_rdata = res_lo[8*i +: 8];
      if (bus_addr == A_RES_HI + REG_AW'(i)) bus_rdata = res_hi[8*i +: 8];
    end
    if (bus_addr == A_CTRL) begin
      bus_rdata[CTRL_OP_BIT]     = mode_op;
      bus_rdata[CTRL_SIGNED_BIT] = mode_sgn;
    end
    if (bus_addr == A_STATUS) begin
      bus_rdata[STAT_BUSY_BIT] = busy;
      bus_rdata[STAT_DZ_BIT]   = dz;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: one instance without and one with
// auto-start, hand-computed results, latency and handshake checks.
module tb_mul_div_unit;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [4:0] bus_addr = '0;
  logic [7:0] bus_wdata = '0;
  logic       we_a = 1'b0, we_b = 1'b0;
  logic [7:0] rdata_a, rdata_b, rdata;
  logic       busy_a, busy_b, done_a, done_b, cur_busy, cur_done;
  logic       sel = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 CLK = ~CLK;

  mul_div_unit #(.WIDTH(32), .REG_AW(5), .AUTO_START(0)) dut (
    .CLK(CLK), .RST(RST), .bus_addr(bus_addr), .bus_we(we_a), .bus_wdata(bus_wdata),
    .bus_rdata(rdata_a), .busy(busy_a), .done(done_a)
  );

  mul_div_unit #(.WIDTH(32), .REG_AW(5), .AUTO_START(1)) dut_auto (
    .CLK(CLK), .RST(RST), .bus_addr(bus_addr), .bus_we(we_b), .bus_wdata(bus_wdata),
    .bus_rdata(rdata_b), .busy(busy_b), .done(done_b)
  );

  assign rdata    = sel ? rdata_b : rdata_a;
  assign cur_busy = sel ? busy_b : busy_a;
  assign cur_done = sel ? done_b : done_a;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wr(input logic [4:0] addr, input logic [7:0] data);
    bus_addr  = addr;
    bus_wdata = data;
    if (sel) we_b = 1'b1;
    else     we_a = 1'b1;
    @(negedge CLK);
    we_a = 1'b0;
    we_b = 1'b0;
  endtask

  task automatic wr_word(input logic [4:0] base, input logic [31:0] w);
    for (int i = 0; i < 4; i++) wr(base + 5'(i), w[8*i +: 8]);
  endtask

  task automatic rd_word(input logic [4:0] base, output logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      bus_addr = base + 5'(i);
      #1;
      w[8*i +: 8] = rdata;
    end
    @(negedge CLK);
  endtask

  task automatic rd_byte(input logic [4:0] addr, output logic [7:0] v);
    bus_addr = addr;
    #1;
    v = rdata;
    @(negedge CLK);
  endtask

  // Observes a fixed 70-cycle window starting the cycle after the start
  // write; k1/k2 inject a bus write in that cycle of the window.
  task automatic run_mon(input int k1, input logic [4:0] a1, input logic [7:0] d1,
                         input int k2, input logic [4:0] a2, input logic [7:0] d2,
                         output int bcnt, output int dcnt, output int dat);
    bcnt = 0; dcnt = 0; dat = -1;
    for (int k = 0; k < 70; k++) begin
      if (cur_busy) bcnt++;
      if (cur_done) begin dcnt++; dat = k; end
      if (k == k1 || k == k2) begin
        bus_addr  = (k == k1) ? a1 : a2;
        bus_wdata = (k == k1) ? d1 : d2;
        if (sel) we_b = 1'b1;
        else     we_a = 1'b1;
      end else begin
        we_a = 1'b0;
        we_b = 1'b0;
      end
      @(negedge CLK);
    end
    we_a = 1'b0;
    we_b = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [7:0] ctrl, input logic [63:0] exp, input logic [7:0] exp_st);
    int bcnt, dcnt, dat;
    logic [31:0] lo, hi;
    logic [7:0]  st;
    wr_word(5'h00, a);
    wr_word(5'h04, b);
    wr(5'h10, ctrl);
    run_mon(-1, 5'h0, 8'h0, -1, 5'h0, 8'h0, bcnt, dcnt, dat);
    check({tag, "_busy_cycles"}, 64'(bcnt), 64'd33);
    check({tag, "_done_count"}, 64'(dcnt), 64'd1);
    check({tag, "_done_at"}, 64'(dat), 64'd33);
    rd_word(5'h08, lo);
    rd_word(5'h0C, hi);
    check({tag, "_result"}, {hi, lo}, exp);
    rd_byte(5'h11, st);
    check({tag, "_status"}, {56'd0, st}, {56'd0, exp_st});
  endtask

  initial begin
    int bcnt, dcnt, dat;
    logic [31:0] w, lo, hi;
    logic [7:0]  v;

    repeat (3) @(negedge CLK);
    RST = 1'b0;

    sel = 1'b0;
    check("rst_busy", {63'd0, busy_a}, 64'd0);
    check("rst_done", {63'd0, done_a}, 64'd0);
    rd_word(5'h00, w);  check("rst_arg0", {32'd0, w}, 64'd0);
    rd_word(5'h08, lo); check("rst_res_lo", {32'd0, lo}, 64'd0);
    rd_word(5'h0C, hi); check("rst_res_hi", {32'd0, hi}, 64'd0);
    rd_byte(5'h11, v);  check("rst_status", {56'd0, v}, 64'd0);
    wr(5'h1F, 8'hAA);
    rd_byte(5'h1F, v);  check("unmapped_read", {56'd0, v}, 64'd0);

    do_op("umul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h80, 64'hFFFF_FFFE_0000_0001, 8'h00);
    do_op("smul_m3x7", 32'hFFFF_FFFD, 32'd7, 8'h82, 64'hFFFF_FFFF_FFFF_FFEB, 8'h00);
    do_op("udiv_100_7", 32'd100, 32'd7, 8'h81, 64'h0000_0002_0000_000E, 8'h00);
    do_op("sdiv_m100_7", 32'hFFFF_FF9C, 32'd7, 8'h83, 64'hFFFF_FFFE_FFFF_FFF2, 8'h00);
    do_op("div_by_zero", 32'd5, 32'd0, 8'h81, 64'h0000_0005_FFFF_FFFF, 8'h02);
    do_op("sdiv_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 8'h83, 64'h0000_0000_8000_0000, 8'h00);

    // Writes during the run: CTRL start/mode ignored, ARG0 updates but not the operation.
    wr_word(5'h00, 32'd6);
    wr_word(5'h04, 32'd7);
    wr(5'h10, 8'h80);
    run_mon(3, 5'h10, 8'h81, 5, 5'h00, 8'h11, bcnt, dcnt, dat);
    check("busy_rules_busy_cycles", 64'(bcnt), 64'd33);
    check("busy_rules_done_count", 64'(dcnt), 64'd1);
    rd_word(5'h08, lo);
    rd_word(5'h0C, hi);
    check("busy_rules_result", {hi, lo}, 64'd42);
    rd_word(5'h00, w);  check("busy_rules_arg0", {32'd0, w}, 64'h11);
    rd_byte(5'h10, v);  check("busy_rules_mode", {56'd0, v}, 64'h00);

    // Start written in the FIX cycle must not launch a second operation.
    wr_word(5'h00, 32'd3);
    wr_word(5'h04, 32'd5);
    wr(5'h10, 8'h80);
    run_mon(32, 5'h10, 8'h81, -1, 5'h0, 8'h0, bcnt, dcnt, dat);
    check("fix_collide_busy_cycles", 64'(bcnt), 64'd33);
    check("fix_collide_done_count", 64'(dcnt), 64'd1);
    rd_word(5'h08, lo); check("fix_collide_result", {32'd0, lo}, 64'd15);
    rd_byte(5'h10, v);  check("fix_collide_mode", {56'd0, v}, 64'h00);

    // Reset in the middle of an operation.
    wr_word(5'h00, 32'd9);
    wr(5'h10, 8'h80);
    repeat (10) @(negedge CLK);
    check("midrst_busy_before", {63'd0, busy_a}, 64'd1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    run_mon(-1, 5'h0, 8'h0, -1, 5'h0, 8'h0, bcnt, dcnt, dat);
    check("midrst_busy_cycles", 64'(bcnt), 64'd0);
    check("midrst_done_count", 64'(dcnt), 64'd0);
    rd_word(5'h08, lo); check("midrst_res_lo", {32'd0, lo}, 64'd0);
    rd_word(5'h0C, hi); check("midrst_res_hi", {32'd0, hi}, 64'd0);
    rd_word(5'h00, w);  check("midrst_arg0", {32'd0, w}, 64'd0);

    // Auto-start instance: mode programmed without start, ARG1 top byte launches.
    sel = 1'b1;
    wr(5'h10, 8'h03);
    rd_byte(5'h11, v);  check("auto_mode_only_status", {56'd0, v}, 64'h00);
    wr_word(5'h00, 32'hFFFF_FF9C);
    wr(5'h04, 8'hF9);
    wr(5'h05, 8'hFF);
    wr(5'h06, 8'hFF);
    rd_byte(5'h11, v);  check("auto_low_bytes_status", {56'd0, v}, 64'h00);
    wr(5'h07, 8'hFF);
    run_mon(-1, 5'h0, 8'h0, -1, 5'h0, 8'h0, bcnt, dcnt, dat);
    check("auto_busy_cycles", 64'(bcnt), 64'd33);
    check("auto_done_count", 64'(dcnt), 64'd1);
    check("auto_done_at", 64'(dat), 64'd33);
    rd_word(5'h08, lo);
    rd_word(5'h0C, hi);
    check("auto_sdiv_result", {hi, lo}, 64'hFFFF_FFFE_0000_000E);
    rd_word(5'h04, w);  check("auto_arg1", {32'd0, w}, 64'hFFFF_FFF9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
